// File: rtl/wfg_wishbone_master.sv
// Wishbone classic initiator: each accepted command becomes one single
// read/write transfer, and its result is returned on a valid/ready response stream.
module wfg_wishbone_master #(
    parameter int BUSW    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [BUSW-1:0]   cmd_adr_i,
    input  logic [BUSW-1:0]   cmd_dat_i,
    input  logic [BUSW/8-1:0] cmd_sel_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [BUSW-1:0]   rsp_dat_o,
    output logic              rsp_err_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [BUSW-1:0]   wbm_adr_o,
    output logic [BUSW-1:0]   wbm_dat_o,
    output logic [BUSW/8-1:0] wbm_sel_o,
    input  logic              wbm_ack_i,
    input  logic [BUSW-1:0]   wbm_dat_i
);

    localparam int SELW = BUSW / 8;
    localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = (TIMEOUT > 0) ? CNTW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t          r_state, w_state_next;
    logic            r_cyc, w_cyc_next;
    logic            r_we, w_we_next;
    logic [BUSW-1:0] r_adr, w_adr_next;
    logic [BUSW-1:0] r_dat, w_dat_next;
    logic [SELW-1:0] r_sel, w_sel_next;
    logic [CNTW-1:0] r_cnt, w_cnt_next;
    logic            r_rsp_valid, w_rsp_valid_next;
    logic [BUSW-1:0] r_rsp_dat, w_rsp_dat_next;
    logic            r_rsp_err, w_rsp_err_next;
    logic            w_timeout;

    // With TIMEOUT==0 the counter still runs but is never compared.
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state     <= ST_IDLE;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cyc       <= w_cyc_next;
            r_we        <= w_we_next;
            r_adr       <= w_adr_next;
            r_dat       <= w_dat_next;
            r_sel       <= w_sel_next;
            r_cnt       <= w_cnt_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_dat   <= w_rsp_dat_next;
            r_rsp_err   <= w_rsp_err_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cyc_next       = r_cyc;
        w_we_next        = r_we;
        w_adr_next       = r_adr;
        w_dat_next       = r_dat;
        w_sel_next       = r_sel;
        w_cnt_next       = r_cnt;
        w_rsp_valid_next = r_rsp_valid;
        w_rsp_dat_next   = r_rsp_dat;
        w_rsp_err_next   = r_rsp_err;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    w_we_next    = cmd_we_i;
                    w_adr_next   = cmd_adr_i;
                    w_dat_next   = cmd_dat_i;
                    w_sel_next   = cmd_sel_i;
                    w_cyc_next   = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = ST_BUS;
                end
            end
            ST_BUS: begin
                w_cnt_next = r_cnt + 1'b1;
                // Ack takes priority over a timeout landing on the same cycle.
                if (wbm_ack_i) begin
                    w_cyc_next       = 1'b0;
                    w_rsp_dat_next   = r_we ? '0 : wbm_dat_i;
                    w_rsp_err_next   = 1'b0;
                    w_rsp_valid_next = 1'b1;
                    w_state_next     = ST_RSP;
                end else if (w_timeout) begin
                    w_cyc_next       = 1'b0;
                    w_rsp_dat_next   = '0;
                    w_rsp_err_next   = 1'b1;
                    w_rsp_valid_next = 1'b1;
                    w_state_next     = ST_RSP;
                end
            end
            ST_RSP: begin
                // Acks arriving here (e.g. a slave's trailing ack) are ignored.
                if (rsp_ready_i) begin
                    w_rsp_valid_next = 1'b0;
                    w_state_next     = ST_IDLE;
                end
            end
            default: begin
                w_cyc_next       = 1'b0;
                w_rsp_valid_next = 1'b0;
                w_state_next     = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready_o = (r_state == ST_IDLE);
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_dat_o   = r_rsp_dat;
    assign rsp_err_o   = r_rsp_err;
    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_cyc;
    assign wbm_we_o    = r_we;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;
    assign wbm_sel_o   = r_sel;

endmodule

// File: tb/tb_wfg_wishbone_master.sv
// Bench for wfg_wishbone_master: a stim_sine-like register slave with selectable
// ack behaviour, table-driven transfers with a response scoreboard, and reset corner cases.
module tb_wfg_wishbone_master;

    localparam int BUSW    = 32;
    localparam int TIMEOUT = 16;

    localparam int M_REG   = 0;  // registered ack, one cycle
    localparam int M_TRAIL = 1;  // registered ack that trails one cycle after cyc drops
    localparam int M_NONE  = 2;  // never acks
    localparam int M_LATE  = 3;  // ack on the 16th bus cycle, plus a trailing ack

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_we = 1'b0;
    logic [BUSW-1:0]   cmd_adr = '0;
    logic [BUSW-1:0]   cmd_dat = '0;
    logic [BUSW/8-1:0] cmd_sel = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [BUSW-1:0]   rsp_dat;
    logic              rsp_err;
    logic              wbm_cyc, wbm_stb, wbm_we;
    logic [BUSW-1:0]   wbm_adr, wbm_dat_o, wbm_dat_i;
    logic [BUSW/8-1:0] wbm_sel;
    logic              wbm_ack;

    always #5 clk = ~clk;

    wfg_wishbone_master #(.BUSW(BUSW), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_we_i   (cmd_we),
        .cmd_adr_i  (cmd_adr),
        .cmd_dat_i  (cmd_dat),
        .cmd_sel_i  (cmd_sel),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_dat_o  (rsp_dat),
        .rsp_err_o  (rsp_err),
        .wbm_cyc_o  (wbm_cyc),
        .wbm_stb_o  (wbm_stb),
        .wbm_we_o   (wbm_we),
        .wbm_adr_o  (wbm_adr),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_sel_o  (wbm_sel),
        .wbm_ack_i  (wbm_ack),
        .wbm_dat_i  (wbm_dat_i)
    );

    // Slave: CTRL/INC/GAIN/OFFSET at 0x0/0x4/0x8/0xC, INC resets to 0x1000.
    int          slv_mode = M_REG;
    logic [31:0] slv_regs [4];
    logic        slv_ack;
    int          slv_bcnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slv_regs[0] <= 32'h0;
            slv_regs[1] <= 32'h0000_1000;
            slv_regs[2] <= 32'h0;
            slv_regs[3] <= 32'h0;
            slv_ack     <= 1'b0;
            slv_bcnt    <= 0;
        end else begin
            slv_bcnt <= wbm_cyc ? slv_bcnt + 1 : 0;
            case (slv_mode)
                M_REG:   slv_ack <= wbm_cyc & wbm_stb & ~slv_ack;
                M_TRAIL: slv_ack <= wbm_cyc & wbm_stb;
                M_LATE:  slv_ack <= wbm_cyc & wbm_stb & ((slv_bcnt == 14) | slv_ack);
                default: slv_ack <= 1'b0;
            endcase
            if (wbm_cyc && wbm_stb && slv_ack && wbm_we) begin
                for (int b = 0; b < 4; b++)
                    if (wbm_sel[b]) slv_regs[wbm_adr[3:2]][8*b +: 8] <= wbm_dat_o[8*b +: 8];
            end
        end
    end

    assign wbm_ack   = slv_ack;
    assign wbm_dat_i = slv_regs[wbm_adr[3:2]];

    // Counts every rising edge of rsp_valid so stray responses are caught.
    logic prev_valid = 1'b0;
    int   rises = 0;
    always @(negedge clk) begin
        prev_valid <= rsp_valid;
        if (rsp_valid && !prev_valid) rises <= rises + 1;
    end

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          mode;
        int          hold;
        logic [31:0] exp_dat;
        logic        exp_err;
        int          exp_lat;
        int          exp_cyc;
    } vec_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
    } rsp_t;

    vec_t vecs [12];
    rsp_t sb_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send_cmd(input vec_t v, output bit ok);
        int n;
        cmd_we    = v.we;
        cmd_adr   = v.adr;
        cmd_dat   = v.dat;
        cmd_sel   = v.sel;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = cmd_ready;
        check("cmd_accept", {31'b0, cmd_ready}, 32'h1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        vec_t        v;
        bit          ok;
        bit          bus_ok;
        bit          stable;
        int          lat;
        int          cyc_n;
        logic [31:0] hd;
        logic        he;
        rsp_t        e;
        v        = vecs[idx];
        slv_mode = v.mode;
        send_cmd(v, ok);
        if (!ok) return;
        sb_q.push_back('{v.exp_dat, v.exp_err});
        lat    = 1;
        cyc_n  = 0;
        bus_ok = 1'b1;
        while (!rsp_valid && lat < 40) begin
            if (wbm_stb !== wbm_cyc || cmd_ready) bus_ok = 1'b0;
            if (wbm_cyc) begin
                cyc_n++;
                if (wbm_adr !== v.adr || wbm_we !== v.we || wbm_sel !== v.sel) bus_ok = 1'b0;
                if (v.we && wbm_dat_o !== v.dat) bus_ok = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        check($sformatf("v%0d rsp_latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d cyc_cycles", idx), cyc_n, v.exp_cyc);
        check($sformatf("v%0d bus_signals", idx), {31'b0, bus_ok}, 32'h1);
        if (!rsp_valid) return;
        hd     = rsp_dat;
        he     = rsp_err;
        stable = 1'b1;
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_dat !== hd || rsp_err !== he || cmd_ready || wbm_cyc) stable = 1'b0;
        end
        if (v.hold > 0) check($sformatf("v%0d rsp_hold", idx), {31'b0, stable}, 32'h1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check($sformatf("v%0d valid_cleared", idx), {31'b0, rsp_valid}, 32'h0);
        check($sformatf("v%0d ready_after", idx), {31'b0, cmd_ready}, 32'h1);
        if (sb_q.size() == 0) begin
            check($sformatf("v%0d scoreboard_empty", idx), 32'h1, 32'h0);
        end else begin
            e = sb_q.pop_front();
            check($sformatf("v%0d rsp_dat", idx), hd, e.dat);
            check($sformatf("v%0d rsp_err", idx), {31'b0, he}, {31'b0, e.err});
        end
        $display("[TB] vec %0d we=%0b adr=0x%0h -> dat=0x%08h err=%0b lat=%0d cyc=%0d",
                 idx, v.we, v.adr, hd, he, lat, cyc_n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v;
        bit          ok;
        bit          quiet;
        int          n;
        int          exp_rises;

        //          we    adr    dat            sel    mode     hold exp_dat        err  lat cyc
        vecs[0]  = '{1'b1, 32'h0, 32'h0000_0001, 4'hF, M_REG,   0, 32'h0000_0000, 1'b0,  3,  2};
        vecs[1]  = '{1'b0, 32'h4, 32'h0,         4'hF, M_REG,   0, 32'h0000_1000, 1'b0,  3,  2};
        vecs[2]  = '{1'b1, 32'h8, 32'h0000_2345, 4'hF, M_REG,   0, 32'h0000_0000, 1'b0,  3,  2};
        vecs[3]  = '{1'b0, 32'h8, 32'h0,         4'hF, M_REG,   0, 32'h0000_2345, 1'b0,  3,  2};
        vecs[4]  = '{1'b0, 32'h0, 32'h0,         4'hF, M_REG,   0, 32'h0000_0001, 1'b0,  3,  2};
        vecs[5]  = '{1'b0, 32'h4, 32'h0,         4'hF, M_NONE,  0, 32'h0000_0000, 1'b1, 17, 16};
        vecs[6]  = '{1'b0, 32'h8, 32'h0,         4'hF, M_REG,   0, 32'h0000_2345, 1'b0,  3,  2};
        vecs[7]  = '{1'b1, 32'hC, 32'hDEAD_BEEF, 4'h3, M_TRAIL, 5, 32'h0000_0000, 1'b0,  3,  2};
        vecs[8]  = '{1'b0, 32'hC, 32'h0,         4'hF, M_REG,   5, 32'h0000_BEEF, 1'b0,  3,  2};
        vecs[9]  = '{1'b0, 32'h8, 32'h0,         4'hF, M_LATE,  2, 32'h0000_2345, 1'b0, 17, 16};
        vecs[10] = '{1'b1, 32'h0, 32'h0000_0005, 4'hF, M_LATE,  0, 32'h0000_0000, 1'b0, 17, 16};
        vecs[11] = '{1'b0, 32'h0, 32'h0,         4'hF, M_TRAIL, 0, 32'h0000_0005, 1'b0,  3,  2};

        // Reset state while reset is held.
        repeat (3) @(negedge clk);
        check("rst cmd_ready", {31'b0, cmd_ready}, 32'h1);
        check("rst cyc_stb", {30'b0, wbm_cyc, wbm_stb}, 32'h0);
        check("rst rsp", {30'b0, rsp_valid, rsp_err}, 32'h0);
        check("rst rsp_dat", rsp_dat, 32'h0);
        check("rst wbm_adr", wbm_adr, 32'h0);
        check("rst wbm_dat", wbm_dat_o, 32'h0);
        check("rst wbm_we_sel", {27'b0, wbm_we, wbm_sel}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_vec(i);

        // Bus signals keep their last values while idle.
        repeat (3) @(negedge clk);
        check("idle adr_hold", wbm_adr, 32'h0);
        check("idle cyc_low", {31'b0, wbm_cyc}, 32'h0);

        // Reset mid-BUS, between clock edges.
        slv_mode = M_NONE;
        v = '{1'b0, 32'h4, 32'h0, 4'hF, M_NONE, 0, 32'h0, 1'b0, 0, 0};
        send_cmd(v, ok);
        repeat (4) @(negedge clk);
        check("busrst cyc_before", {31'b0, wbm_cyc}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("busrst cyc_stb", {30'b0, wbm_cyc, wbm_stb}, 32'h0);
        check("busrst rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("busrst cmd_ready", {31'b0, cmd_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if (wbm_cyc || rsp_valid) quiet = 1'b0;
        end
        check("busrst no_response", {31'b0, quiet}, 32'h1);
        $display("[TB] reset mid-BUS: cyc=%0b rsp_valid=%0b quiet=%0b", wbm_cyc, rsp_valid, quiet);

        // Reset while a response is waiting.
        slv_mode = M_REG;
        v = '{1'b0, 32'h4, 32'h0, 4'hF, M_REG, 0, 32'h0, 1'b0, 0, 0};
        send_cmd(v, ok);
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rsprst valid_before", {31'b0, rsp_valid}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rsprst rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rsprst cmd_ready", {31'b0, cmd_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        $display("[TB] reset in RSP: rsp_valid=%0b cmd_ready=%0b", rsp_valid, cmd_ready);

        // Twelve table responses plus the one dropped by the RSP reset.
        exp_rises = 13;
        check("rsp_pulse_count", rises, exp_rises);
        check("scoreboard_drained", sb_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
